// File: rtl/vsdma_line_writer.sv
// vsdma_line_writer: buffers an incoming pixel-word stream in a first-word-fall-through FIFO
// and issues one vsdma_wareq write request for each full line buffered. Line addresses are
// generated over a ring of frame buffers, and the last completed frame is published.
// Optional build macro: VSDMA_LW_OVF_CNT_EN adds the ovf_cnt dropped-word counter output.
module vsdma_line_writer #(
    parameter int unsigned                 M_AXI_ADDR_WIDTH = 28,
    parameter int unsigned                 M_AXI_DATA_WIDTH = 256,
    parameter int unsigned                 LINE_WORDS       = 240,
    parameter int unsigned                 LINES_PER_FRAME  = 720,
    parameter logic [M_AXI_ADDR_WIDTH-1:0] FRAME_BASE       = '0,
    parameter logic [M_AXI_ADDR_WIDTH-1:0] FRAME_SIZE       = 28'h0200000,
    parameter int unsigned                 NUM_FRAMES       = 3,
    parameter int unsigned                 FIFO_DEPTH       = 512
) (
    input  logic                        M_AXI_ACLK,
    input  logic                        M_AXI_ARESETN,
    input  logic [M_AXI_DATA_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    input  logic                        in_sof,
    output logic [M_AXI_ADDR_WIDTH-1:0] vsdma_waddr,
    output logic                        vsdma_wareq,
    output logic [15:0]                 vsdma_wsize,
    input  logic                        vsdma_wbusy,
    output logic [M_AXI_DATA_WIDTH-1:0] vsdma_wdata,
    input  logic                        vsdma_wvalid,
    output logic                        vsdma_wready,
    output logic                        frame_done,
    output logic [1:0]                  done_frame_idx,
    output logic                        ovf_flag
`ifdef VSDMA_LW_OVF_CNT_EN
    ,
    output logic [15:0]                 ovf_cnt
`endif
);

    localparam int unsigned ADDR_STEP = M_AXI_DATA_WIDTH / 32;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LINE_W    = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

    localparam logic [LVL_W-1:0]            LVL_FULL    = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]            LVL_LINE    = LVL_W'(LINE_WORDS);
    localparam logic [LVL_W-1:0]            BEAT_LAST   = LVL_W'(LINE_WORDS - 1);
    localparam logic [LINE_W-1:0]           LINE_LAST   = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [1:0]                  FRAME_LAST  = 2'(NUM_FRAMES - 1);
    localparam logic [M_AXI_ADDR_WIDTH-1:0] LINE_STRIDE = M_AXI_ADDR_WIDTH'(LINE_WORDS * ADDR_STEP);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_t;

    // FIFO storage: each entry is {sof, data}
    logic [M_AXI_DATA_WIDTH:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [LVL_W-1:0]          r_level;
    logic                      r_ovf;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic [M_AXI_DATA_WIDTH:0] w_head;
    logic                      w_head_sof;

    // Line sequencing
    state_t                        r_state;
    state_t                        w_state_next;
    logic [LVL_W-1:0]              r_beat;
    logic [LINE_W-1:0]             r_line;
    logic [1:0]                    r_frame;
    logic [M_AXI_ADDR_WIDTH-1:0]   r_waddr;
    logic                          r_frame_done;
    logic [1:0]                    r_done_idx;

    logic                          w_start;
    logic                          w_abandon;
    logic                          w_last_line;
    logic                          w_fd_set;
    logic [1:0]                    w_frame_inc;
    logic [1:0]                    w_frame_eff;
    logic [LINE_W-1:0]             w_line_eff;
    logic [M_AXI_ADDR_WIDTH-1:0]   w_addr;

    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == '0);
    assign w_push     = in_valid && !w_full;
    assign w_pop      = vsdma_wvalid && !w_empty;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_sof = w_head[M_AXI_DATA_WIDTH];

    // FIFO data array; contents are don't-care until the pointers say otherwise
    always_ff @(posedge M_AXI_ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_sof, in_data};
        end
    end

    // FIFO pointers, fill level and sticky overflow flag
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (in_valid && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // A head-of-line sof seen mid-frame abandons the frame before its address is formed
    assign w_last_line = (r_line == LINE_LAST);
    assign w_frame_inc = (r_frame == FRAME_LAST) ? 2'd0 : r_frame + 2'd1;
    assign w_abandon   = w_head_sof && (r_line != '0);
    assign w_frame_eff = w_abandon ? w_frame_inc : r_frame;
    assign w_line_eff  = w_abandon ? '0 : r_line;
    assign w_addr      = FRAME_BASE
                       + M_AXI_ADDR_WIDTH'(w_frame_eff) * FRAME_SIZE
                       + M_AXI_ADDR_WIDTH'(w_line_eff) * LINE_STRIDE;

    // Next-state decode for the line request sequencer
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if ((r_level >= LVL_LINE) && !vsdma_wbusy) begin
                    w_state_next = StReq;
                    w_start      = 1'b1;
                end
            end
            StReq:  w_state_next = StXfer;
            StXfer: begin
                if (w_pop && (r_beat == BEAT_LAST)) begin
                    w_state_next = StDone;
                end
            end
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // frame_done and done_frame_idx both launch on the edge entering DONE
    assign w_fd_set = (r_state == StXfer) && (w_state_next == StDone) && w_last_line;

    // Sequencer state register
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Beat, line and frame counters, request address and completion reporting
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_beat       <= '0;
            r_line       <= '0;
            r_frame      <= 2'd0;
            r_waddr      <= '0;
            r_frame_done <= 1'b0;
            r_done_idx   <= 2'd0;
        end else begin
            r_frame_done <= w_fd_set;
            if (w_start) begin
                r_waddr <= w_addr;
                r_frame <= w_frame_eff;
                r_line  <= w_line_eff;
            end
            if (r_state == StReq) begin
                r_beat <= '0;
            end else if ((r_state == StXfer) && w_pop) begin
                r_beat <= r_beat + LVL_W'(1);
            end
            if (w_fd_set) begin
                r_done_idx <= r_frame;
            end
            if (r_state == StDone) begin
                if (w_last_line) begin
                    r_line  <= '0;
                    r_frame <= w_frame_inc;
                end else begin
                    r_line <= r_line + LINE_W'(1);
                end
            end
        end
    end

`ifdef VSDMA_LW_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    // Saturating dropped-word count, restarted whenever a frame completes
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_ovf_cnt <= 16'd0;
        end else if (w_fd_set) begin
            r_ovf_cnt <= 16'd0;
        end else if (in_valid && w_full && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    assign vsdma_waddr    = r_waddr;
    assign vsdma_wareq    = (r_state == StReq);
    assign vsdma_wsize    = 16'(LINE_WORDS);
    assign vsdma_wdata    = w_empty ? '0 : w_head[M_AXI_DATA_WIDTH-1:0];
    assign vsdma_wready   = !w_empty;
    assign frame_done     = r_frame_done;
    assign done_frame_idx = r_done_idx;
    assign ovf_flag       = r_ovf;

endmodule

// File: tb/tb_vsdma_line_writer.sv
// Testbench for vsdma_line_writer: directed sequence with random pixel data, random sof and
// random pop gaps, checked against a queue-based reference model of the line writer.
module tb_vsdma_line_writer;

    localparam int          AW    = 28;
    localparam int          DW    = 64;
    localparam int          LW    = 4;
    localparam int          LPF   = 2;
    localparam int          NF    = 3;
    localparam int          DEPTH = 8;
    localparam int          STEP  = DW / 32;
    localparam logic [AW-1:0] FB  = 28'h0001000;
    localparam logic [AW-1:0] FS  = 28'h0000400;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_sof;
    logic [AW-1:0] vsdma_waddr;
    logic          vsdma_wareq;
    logic [15:0]   vsdma_wsize;
    logic          vsdma_wbusy;
    logic [DW-1:0] vsdma_wdata;
    logic          vsdma_wvalid;
    logic          vsdma_wready;
    logic          frame_done;
    logic [1:0]    done_frame_idx;
    logic          ovf_flag;
`ifdef VSDMA_LW_OVF_CNT_EN
    logic [15:0]   ovf_cnt;
`endif

    vsdma_line_writer #(
        .M_AXI_ADDR_WIDTH (AW),
        .M_AXI_DATA_WIDTH (DW),
        .LINE_WORDS       (LW),
        .LINES_PER_FRAME  (LPF),
        .FRAME_BASE       (FB),
        .FRAME_SIZE       (FS),
        .NUM_FRAMES       (NF),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .M_AXI_ACLK     (clk),
        .M_AXI_ARESETN  (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .vsdma_waddr    (vsdma_waddr),
        .vsdma_wareq    (vsdma_wareq),
        .vsdma_wsize    (vsdma_wsize),
        .vsdma_wbusy    (vsdma_wbusy),
        .vsdma_wdata    (vsdma_wdata),
        .vsdma_wvalid   (vsdma_wvalid),
        .vsdma_wready   (vsdma_wready),
        .frame_done     (frame_done),
        .done_frame_idx (done_frame_idx),
        .ovf_flag       (ovf_flag)
`ifdef VSDMA_LW_OVF_CNT_EN
        ,
        .ovf_cnt        (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sof;
        logic [DW-1:0] data;
    } word_t;

    // Reference model state
    word_t q[$];
    int    m_frame;
    int    m_line;
    int    m_done;
    int    m_ovf_cnt;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int f, input int l);
        logic [AW-1:0] a;
        a = FB + AW'(f) * FS + AW'(l * LW * STEP);
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_frame   = 0;
        m_line    = 0;
        m_done    = 0;
        m_ovf_cnt = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_wareq", vsdma_wareq, 0);
        check("rst_waddr", vsdma_waddr, 0);
        check("rst_wready", vsdma_wready, 0);
        check("rst_wdata", vsdma_wdata, 0);
        check("rst_wsize", vsdma_wsize, LW);
        check("rst_frame_done", frame_done, 0);
        check("rst_done_idx", done_frame_idx, 0);
        check("rst_ovf_flag", ovf_flag, 0);
`ifdef VSDMA_LW_OVF_CNT_EN
        check("rst_ovf_cnt", ovf_cnt, 0);
`endif
    endtask

    task automatic push_word(input bit sof);
        logic [DW-1:0] d;
        d        = {$urandom, $urandom};
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        if (q.size() < DEPTH) begin
            q.push_back('{sof, d});
        end else if (m_ovf_cnt < 65535) begin
            m_ovf_cnt++;
        end
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_req(input int exp_lat);
        int n;
        n = 0;
        while (!vsdma_wareq && n < 20) begin
            step();
            n++;
        end
        check("wareq_seen", vsdma_wareq, 1);
        if (exp_lat >= 0) check("wareq_latency", n, exp_lat);
    endtask

    // One full request/transfer/done sequence, checked against the model
    task automatic serve_line(input int exp_lat, input bit rand_gap);
        int pops;
        bit fd;
        wait_req(exp_lat);
        if (!vsdma_wareq) return;
        if (q.size() > 0 && q[0].sof && m_line != 0) begin
            m_frame = (m_frame + 1) % NF;
            m_line  = 0;
        end
        check("waddr", vsdma_waddr, exp_addr(m_frame, m_line));
        check("wsize", vsdma_wsize, LW);
        step();
        check("wareq_one_cycle", vsdma_wareq, 0);
        pops = 0;
        for (int guard = 0; pops < LW && guard < 100; guard++) begin
            vsdma_wvalid = rand_gap ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (vsdma_wvalid && q.size() > 0) begin
                check("wready", vsdma_wready, 1);
                check("wdata", vsdma_wdata, q[0].data);
            end
            step();
            if (vsdma_wvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                pops++;
            end
            vsdma_wvalid = 1'b0;
        end
        fd = (m_line + 1 == LPF);
        check("frame_done", frame_done, fd);
        if (fd) begin
            m_done    = m_frame;
            m_line    = 0;
            m_frame   = (m_frame + 1) % NF;
            m_ovf_cnt = 0;
        end else begin
            m_line++;
        end
        check("done_frame_idx", done_frame_idx, m_done);
        check("wready_after_line", vsdma_wready, q.size() > 0);
        step();
        check("frame_done_pulse", frame_done, 0);
    endtask

    task automatic do_line(input bit sof, input bit rand_gap);
        for (int i = 0; i < LW; i++) push_word(sof && (i == 0));
        serve_line(1, rand_gap);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        in_sof       = 1'b0;
        vsdma_wbusy  = 1'b0;
        vsdma_wvalid = 1'b0;
        model_reset();
        repeat (3) step();
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // Single line at frame 0, line 0
        do_line(1'b1, 1'b0);

        // Frame wrap: six lines, sof on each frame's first line
        for (int i = 0; i < 6; i++) do_line(m_line == 0, 1'b0);

        // Early sof on line 1 of frame 0 abandons the frame
        do_line(1'b1, 1'b0);

        // Overflow with busy held high, then busy gating release
        vsdma_wbusy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_word(1'b0);
            check("no_wareq_busy", vsdma_wareq, 0);
        end
        check("ovf_flag", ovf_flag, 1);
        check("wready_full", vsdma_wready, 1);
`ifdef VSDMA_LW_OVF_CNT_EN
        check("ovf_cnt", ovf_cnt, m_ovf_cnt);
`endif
        repeat (3) begin
            step();
            check("no_wareq_busy_hold", vsdma_wareq, 0);
        end
        vsdma_wbusy = 1'b0;
        serve_line(1, 1'b0);
        serve_line(1, 1'b1);
        check("ovf_flag_sticky", ovf_flag, 1);

        // Reset in the middle of a transfer
        for (int i = 0; i < LW; i++) push_word(1'b0);
        wait_req(1);
        step();
        vsdma_wvalid = 1'b1;
        step();
        step();
        vsdma_wvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        check("wready_after_reset", vsdma_wready, 0);
        check("wareq_after_reset", vsdma_wareq, 0);
        do_line(1'b1, 1'b0);

        // Randomized lines: random sof placement and pop gaps
        for (int k = 0; k < 12; k++) do_line($urandom_range(0, 2) == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vsdma_line_writer.md
# vsdma_line_writer

Upstream feeder for the VSDMA write channel. It accepts a wide pixel-word stream in the AXI clock domain and buffers it in an internal first-word-fall-through FIFO. Each time one full video line is buffered, it issues one `vsdma_wareq` write request. Addresses are computed over a ring of frame buffers, and the block publishes which frame was last completed for the read side.

## Interface
Parameters:
- `M_AXI_ADDR_WIDTH`, 28: address width.
- `M_AXI_DATA_WIDTH`, 256: word width; the address step per word is `ADDR_STEP = M_AXI_DATA_WIDTH/32`.
- `LINE_WORDS`, 240: words per line; this is the value driven on `vsdma_wsize`. Range 1..`FIFO_DEPTH`.
- `LINES_PER_FRAME`, 720: lines per frame.
- `FRAME_BASE`, 0: address of frame 0.
- `FRAME_SIZE`, 28'h0200000: address distance between frames.
- `NUM_FRAMES`, 3: frames in the ring, 1..4.
- `FIFO_DEPTH`, 512: FIFO words, power of 2, must be at least 2×`LINE_WORDS`.

Ports (clock and reset first):
- `M_AXI_ACLK`  in  1  clock.
- `M_AXI_ARESETN`  in  1  asynchronous active-low reset.
- `in_data`  in  `M_AXI_DATA_WIDTH`  pixel word.
- `in_valid`  in  1  word strobe; there is no backpressure.
- `in_sof`  in  1  first word of a frame; qualified by `in_valid`.
- `vsdma_waddr`  out  `M_AXI_ADDR_WIDTH`  line start address.
- `vsdma_wareq`  out  1  one-cycle request pulse.
- `vsdma_wsize`  out  16  constant `LINE_WORDS`.
- `vsdma_wbusy`  in  1  downstream busy.
- `vsdma_wdata`  out  `M_AXI_DATA_WIDTH`  FIFO head word.
- `vsdma_wvalid`  in  1  downstream consumed the head word (pop).
- `vsdma_wready`  out  1  FIFO not empty.
- `frame_done`  out  1  one-cycle pulse when a frame's last line has been written.
- `done_frame_idx`  out  2  index of the most recently completed frame.
- `ovf_flag`  out  1  sticky; set when a word was dropped on FIFO full.

## Operation
- **FIFO storage:** each entry is `{sof, data}`.
  - Push on `in_valid` when the FIFO is not full.
  - Pop on `vsdma_wvalid`.
  - Simultaneous push and pop is legal and leaves the level unchanged.
  - Push while full: the word is dropped and `ovf_flag` is set. Only reset clears it.
  - Pop while empty must not occur; if it does, the level stays at 0.
- **FSM states:**
  - IDLE → REQ when `level >= LINE_WORDS` and `vsdma_wbusy == 0`.
  - REQ: `vsdma_wareq = 1` for exactly one cycle, `vsdma_waddr` is stable, and the beat counter is cleared. Always → XFER.
  - XFER: count pops. When the pop count reaches `LINE_WORDS` → DONE.
  - DONE: update the line and frame counters. → IDLE.
- **Address:** `vsdma_waddr = FRAME_BASE + frame_idx*FRAME_SIZE + line_idx*LINE_WORDS*ADDR_STEP`.
  - The address is registered when the FSM enters REQ.
  - The arithmetic is done at `M_AXI_ADDR_WIDTH` and truncates silently.
- **Start-of-frame handling:** the sof bit of the FIFO head is sampled at IDLE→REQ.
  - If it is set and `line_idx != 0`: the frame is abandoned. `frame_idx` advances (mod `NUM_FRAMES`), `line_idx = 0`, and there is no `frame_done` pulse. This update takes effect before the address is formed.
  - If it is set and `line_idx == 0`: no change.
- **Line and frame completion (in DONE):** `line_idx + 1`.
  - When `line_idx + 1` reaches `LINES_PER_FRAME`: `line_idx = 0`, `done_frame_idx = frame_idx`, `frame_done` is pulsed, and `frame_idx` advances with wrap (`NUM_FRAMES-1` → 0).
- **Reset values:** all outputs 0 except `vsdma_wsize = LINE_WORDS`. FIFO empty, FSM IDLE, `frame_idx = 0`, `line_idx = 0`.
- **Reset mid-line:** asserting reset mid-line aborts everything immediately. The FIFO contents are lost.

## Timing
- The FIFO is first-word-fall-through: a word pushed at edge N appears on `vsdma_wdata`, with `vsdma_wready = 1`, after edge N. That is zero added latency beyond the write register.
- The REQ condition is evaluated on the registered level. `vsdma_wareq` rises on the edge after the level reaches `LINE_WORDS` (one-cycle latency).
- `vsdma_wareq` is never asserted while `vsdma_wbusy = 1` or while the FSM is outside REQ.
- From the end of XFER, there are at least 2 cycles (DONE, then IDLE) before the next `vsdma_wareq`. This guarantees that the downstream busy has been sampled high and has deasserted.
- `frame_done` is asserted in the DONE cycle. `done_frame_idx` is valid from the same edge.
- Pop handshake: `vsdma_wvalid` is a single-cycle accept. The next head word is presented on the following cycle's data.

## Configuration
- `VSDMA_LW_OVF_CNT_EN`:
  - When defined: adds output `ovf_cnt` [15:0], which counts dropped words, saturates at 16'hFFFF, resets to 0, and clears when a `frame_done` pulse is issued.
  - When undefined: the port and its counter are absent. `ovf_flag` behaviour is identical in both builds.

## Test plan
- **Single line:** `LINE_WORDS=4`, push 4 words with sof → one `vsdma_wareq` pulse with `waddr = FRAME_BASE`, `wsize = 4`; 4 pops output words in push order; `wready` then falls to 0.
- **Frame wrap:** `LINES_PER_FRAME=2`, `NUM_FRAMES=3`, 6 lines → addresses per frame are F0 line0 / line1, F1, F2, then F0 again; `frame_done` ×3 with `done_frame_idx` 0, 1, 2.
- **Early sof:** sof on line 1 of frame 0 → that line is written at F1 line 0; no `frame_done` pulse.
- **Overflow:** `FIFO_DEPTH=8`, hold `vsdma_wbusy=1`, push 10 words → 8 words stored; `ovf_flag = 1`; `ovf_cnt = 2` (EN build).
- **Busy gating:** level ≥ `LINE_WORDS` while `vsdma_wbusy=1` → no `wareq`; `wareq` is issued 1 cycle after `wbusy` falls.
- **Reset mid-XFER:** assert reset after 2 of 4 pops → all outputs at reset values; the FIFO is empty after release.
